quadrature_nco: RTL and testbench

//  Parametrised quadrature NCO for the IQ modulator: phase accumulator + runtime-loadable tuning word,

---
 rtl/quadrature_nco_pkg.sv | 40 ++++
 rtl/quadrature_nco_rom.sv | 37 +++
 rtl/quadrature_nco.sv | 144 ++++++++++++++
 tb/tb_quadrature_nco.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quadrature_nco_pkg.sv
// Shared constants for the quadrature NCO: default widths, config FSM
// encodings and the elaboration-time quarter-wave sine table generator.
package quadrature_nco_pkg;

    localparam int NCO_AW = 32;
    localparam int NCO_PW = 12;
    localparam int NCO_OW = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam int SIN_FRAC = 40;
    localparam int SIN_TERMS = 14;
    localparam logic signed [127:0] PI_Q40 = 128'sd3454217652358;

    // round((2^ow-1) * sin((k+0.5)*pi/2^(pw-1))) via a Q40 Taylor series
    function automatic logic [31:0] sin_entry(
        input int k,
        input int pw,
        input int ow
    );
        logic signed [127:0] x;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        logic signed [127:0] r;
        x = (PI_Q40 * 128'(2 * k + 1)) >>> pw;
        term = x;
        sum = x;
        for (int n = 1; n < SIN_TERMS; n++) begin
            term = (term * x) >>> SIN_FRAC;
            term = (term * x) >>> SIN_FRAC;
            term = -term / 128'(2 * n * (2 * n + 1));
            sum = sum + term;
        end
        r = sum * 128'((64'd1 << ow) - 64'd1);
        r = (r + (128'sd1 <<< (SIN_FRAC - 1))) >>> SIN_FRAC;
        return r[31:0];
    endfunction

endpackage

// File: rtl/quadrature_nco_rom.sv
// Quarter-wave sine ROM with two registered read ports, shared by the
// I and Q lanes; contents are generated at elaboration.
module quarter_wave_rom
    import quadrature_nco_pkg::*;
#(
    parameter int PW = NCO_PW,
    parameter int OW = NCO_OW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic [PW-3:0] addr_a,
    input  logic [PW-3:0] addr_b,
    output logic [OW-1:0] data_a,
    output logic [OW-1:0] data_b
);

    localparam int DEPTH = 1 << (PW - 2);

    logic [OW-1:0] lut [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_lut
        localparam logic [31:0] ENTRY = sin_entry(k, PW, OW);
        assign lut[k] = ENTRY[OW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_a <= '0;
            data_b <= '0;
        end else if (ce) begin
            data_a <= lut[addr_a];
            data_b <= lut[addr_b];
        end
    end

endmodule

// File: rtl/quadrature_nco.sv
// Quadrature NCO: phase accumulator with handshaked runtime config,
// five-stage sine/cosine pipeline and valid tracking.
module quadrature_nco
    import quadrature_nco_pkg::*;
#(
    parameter int AW = NCO_AW,
    parameter int PW = NCO_PW,
    parameter int OW = NCO_OW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_cfg_valid,
    output logic          o_cfg_ready,
    input  logic [AW-1:0] i_cfg_ftw,
    input  logic [PW-1:0] i_cfg_poff,
    input  logic          i_cfg_sync,
    output logic          o_valid,
    output logic [OW:0]   o_i,
    output logic [OW:0]   o_q
);

    localparam logic [PW-1:0] QTR = PW'(1) << (PW - 2);

    logic [0:0]    state;
    logic [AW-1:0] sh_ftw;
    logic [PW-1:0] sh_poff;
    logic          sh_sync;
    logic          apply;
    logic          flush;

    logic [AW-1:0] acc;
    logic [AW-1:0] ftw;
    logic [PW-1:0] poff;
    logic [PW-1:0] ph_top;
    logic [4:0]    vld_sr;

    logic [PW-1:0] ph_i;
    logic [PW-1:0] ph_q;
    logic [PW-3:0] idx_i;
    logic [PW-3:0] idx_q;
    logic          neg_i1;
    logic          neg_q1;
    logic [OW-1:0] mag_i;
    logic [OW-1:0] mag_q;
    logic          neg_i2;
    logic          neg_q2;
    logic [OW:0]   val_i;
    logic [OW:0]   val_q;

    assign o_cfg_ready = (state == ST_IDLE);
    assign apply = (state == ST_PEND) && i_ce;
    assign flush = apply && sh_sync;
    assign ph_top = acc[AW-1 -: PW];
    assign o_valid = vld_sr[4];

    // Captured values wait in the shadow until a sample-rate tick
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            sh_ftw <= '0;
            sh_poff <= '0;
            sh_sync <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_cfg_valid) begin
                        sh_ftw <= i_cfg_ftw;
                        sh_poff <= i_cfg_poff;
                        sh_sync <= i_cfg_sync;
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (i_ce) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc <= '0;
            ftw <= '0;
            poff <= '0;
            vld_sr <= '0;
        end else if (i_ce) begin
            acc <= flush ? '0 : acc + ftw;
            vld_sr <= flush ? '0 : {vld_sr[3:0], 1'b1};
            if (apply) begin
                ftw <= sh_ftw;
                poff <= sh_poff;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ph_i <= '0;
            ph_q <= '0;
            idx_i <= '0;
            idx_q <= '0;
            neg_i1 <= 1'b0;
            neg_q1 <= 1'b0;
            neg_i2 <= 1'b0;
            neg_q2 <= 1'b0;
            val_i <= '0;
            val_q <= '0;
            o_i <= '0;
            o_q <= '0;
        end else if (i_ce) begin
            ph_i <= ph_top + poff;
            ph_q <= ph_top + poff + QTR;
            // Odd quadrants read the quarter table backwards
            idx_i <= ph_i[PW-2] ? ~ph_i[PW-3:0] : ph_i[PW-3:0];
            idx_q <= ph_q[PW-2] ? ~ph_q[PW-3:0] : ph_q[PW-3:0];
            neg_i1 <= ph_i[PW-1];
            neg_q1 <= ph_q[PW-1];
            neg_i2 <= neg_i1;
            neg_q2 <= neg_q1;
            val_i <= neg_i2 ? -{1'b0, mag_i} : {1'b0, mag_i};
            val_q <= neg_q2 ? -{1'b0, mag_q} : {1'b0, mag_q};
            o_i <= val_i;
            o_q <= val_q;
        end
    end

    quarter_wave_rom #(
        .PW(PW),
        .OW(OW)
    ) u_rom (
        .clk   (i_clk),
        .reset (i_reset),
        .ce    (i_ce),
        .addr_a(idx_i),
        .addr_b(idx_q),
        .data_a(mag_i),
        .data_b(mag_q)
    );

endmodule

// File: tb/tb_quadrature_nco.sv
// Scoreboard bench for quadrature_nco: a reference phase model pushes
// expected I/Q per sample tick, popped five ticks later.
module tb_quadrature_nco;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ce = 1'b0;
    logic        i_cfg_valid = 1'b0;
    logic        o_cfg_ready;
    logic [31:0] i_cfg_ftw = '0;
    logic [11:0] i_cfg_poff = '0;
    logic        i_cfg_sync = 1'b0;
    logic        o_valid;
    logic [16:0] o_i;
    logic [16:0] o_q;

    quadrature_nco dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_cfg_valid(i_cfg_valid),
        .o_cfg_ready(o_cfg_ready),
        .i_cfg_ftw  (i_cfg_ftw),
        .i_cfg_poff (i_cfg_poff),
        .i_cfg_sync (i_cfg_sync),
        .o_valid    (o_valid),
        .o_i        (o_i),
        .o_q        (o_q)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total = 0;
    int tbl [1024];

    logic [31:0] m_acc;
    logic [31:0] m_ftw;
    logic [11:0] m_poff;
    bit          m_pend;
    logic [31:0] sh_ftw;
    logic [11:0] sh_poff;
    bit          sh_sync;
    int          m_cnt;
    logic [16:0] qi [$];
    logic [16:0] qq [$];
    logic [16:0] exp_i;
    logic [16:0] exp_q;
    bit          exp_v;
    bit          exp_rdy;

    function automatic logic [16:0] exp_sin(input logic [11:0] ph);
        logic [9:0] lo;
        int m;
        lo = ph[9:0];
        case (ph[11:10])
            2'd0: m = tbl[lo];
            2'd1: m = tbl[1023 - int'(lo)];
            2'd2: m = -tbl[lo];
            default: m = -tbl[1023 - int'(lo)];
        endcase
        return 17'(m);
    endfunction

    task automatic model_reset();
        m_acc = '0;
        m_ftw = '0;
        m_poff = '0;
        m_pend = 0;
        m_cnt = 0;
        qi.delete();
        qq.delete();
        qi.push_back(exp_sin(12'd0));
        qq.push_back(exp_sin(12'd1024));
        exp_i = '0;
        exp_q = '0;
        exp_v = 0;
        exp_rdy = 1;
    endtask

    task automatic tick(input bit ce, input bit cv, input logic [31:0] f,
                        input logic [11:0] p, input bit s, output bit took);
        bit rdy;
        logic [11:0] ph;
        i_ce = ce;
        i_cfg_valid = cv;
        i_cfg_ftw = f;
        i_cfg_poff = p;
        i_cfg_sync = s;
        rdy = !m_pend;
        @(posedge i_clk);
        took = rdy && cv;
        if (ce) begin
            if (m_pend && sh_sync) begin
                m_acc = '0;
                m_cnt = 0;
            end else begin
                m_acc = m_acc + m_ftw;
                if (m_cnt < 5) m_cnt++;
            end
            if (m_pend) begin
                m_ftw = sh_ftw;
                m_poff = sh_poff;
                m_pend = 0;
            end
            ph = m_acc[31:20] + m_poff;
            qi.push_back(exp_sin(ph));
            qq.push_back(exp_sin(ph + 12'd1024));
            if (qi.size() == 6) begin
                exp_i = qi.pop_front();
                exp_q = qq.pop_front();
            end
        end
        if (took) begin
            sh_ftw = f;
            sh_poff = p;
            sh_sync = s;
            m_pend = 1;
        end
        exp_v = (m_cnt >= 5);
        exp_rdy = !m_pend;
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (o_valid !== 1'b0 || o_cfg_ready !== 1'b1)
            $display("FAIL reset_ctrl: v=%0b r=%0b, expected v=0 r=1", o_valid, o_cfg_ready);
        else passed++;
        total++;
        if (o_i !== 17'd0 || o_q !== 17'd0)
            $display("FAIL reset_data: i=%h q=%h, expected 0 0", o_i, o_q);
        else passed++;
        @(negedge i_clk);
        i_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        bit took;
        int n;
        tick(1, 1, 32'h4000_0000, 12'd0, 1, took);
        tick(1, 0, '0, '0, 0, took);
        n = 0;
        while (!o_valid && n < 12) begin
            total++;
            if (o_valid !== exp_v || o_cfg_ready !== exp_rdy)
                $display("FAIL basic_prime: v=%0b r=%0b, expected v=%0b r=%0b", o_valid, o_cfg_ready, exp_v, exp_rdy);
            else passed++;
            tick(1, 0, '0, '0, 0, took);
            n++;
        end
        total++;
        if (n != 5) $display("FAIL basic_latency: valid after %0d ticks, expected 5", n);
        else passed++;
        total++;
        if (o_i !== 17'(tbl[0]) || o_q !== 17'(tbl[1023]))
            $display("FAIL basic_first: i=%h q=%h, expected i=%h q=%h", o_i, o_q, 17'(tbl[0]), 17'(tbl[1023]));
        else passed++;
        for (int k = 0; k < 12; k++) begin
            tick(1, 0, '0, '0, 0, took);
            total++;
            if (o_valid !== exp_v || o_cfg_ready !== exp_rdy || (exp_v && (o_i !== exp_i || o_q !== exp_q)))
                $display("FAIL basic_stream: v=%0b r=%0b i=%h q=%h, expected v=%0b r=%0b i=%h q=%h",
                         o_valid, o_cfg_ready, o_i, o_q, exp_v, exp_rdy, exp_i, exp_q);
            else passed++;
        end
    endtask

    task automatic test_ce_toggle();
        bit took;
        for (int k = 0; k < 24; k++) begin
            tick(k % 2 == 0, 0, '0, '0, 0, took);
            total++;
            if (o_valid !== exp_v || o_cfg_ready !== exp_rdy || (exp_v && (o_i !== exp_i || o_q !== exp_q)))
                $display("FAIL ce_toggle: v=%0b r=%0b i=%h q=%h, expected v=%0b r=%0b i=%h q=%h",
                         o_valid, o_cfg_ready, o_i, o_q, exp_v, exp_rdy, exp_i, exp_q);
            else passed++;
        end
    endtask

    task automatic test_reconfig();
        bit took;
        logic [16:0] a;
        logic [16:0] na;
        tick(0, 1, 32'h8000_0000, 12'd0, 0, took);
        for (int k = 0; k < 14; k++) begin
            if (k == 0 || k == 1) tick(0, 0, '0, '0, 0, took);
            else tick(1, 0, '0, '0, 0, took);
            total++;
            if (o_valid !== 1'b1 || o_cfg_ready !== exp_rdy || o_i !== exp_i || o_q !== exp_q)
                $display("FAIL reconfig: v=%0b r=%0b i=%h q=%h, expected v=1 r=%0b i=%h q=%h",
                         o_valid, o_cfg_ready, o_i, o_q, exp_rdy, exp_i, exp_q);
            else passed++;
        end
        a = o_i;
        na = -a;
        tick(1, 0, '0, '0, 0, took);
        total++;
        if (o_i !== na) $display("FAIL reconfig_alt: i=%h, expected %h", o_i, na);
        else passed++;
    endtask

    task automatic test_sync();
        bit took;
        int n;
        tick(1, 1, 32'h4000_0000, 12'd1024, 1, took);
        tick(1, 0, '0, '0, 0, took);
        n = 0;
        while (!o_valid && n < 12) begin
            tick(1, 0, '0, '0, 0, took);
            n++;
        end
        total++;
        if (n != 5) $display("FAIL sync_flush: valid after %0d ticks, expected 5", n);
        else passed++;
        total++;
        if (o_i !== 17'(tbl[1023]) || o_q !== 17'(-tbl[0]))
            $display("FAIL sync_first: i=%h q=%h, expected i=%h q=%h", o_i, o_q, 17'(tbl[1023]), 17'(-tbl[0]));
        else passed++;
        for (int k = 0; k < 8; k++) begin
            tick(1, 0, '0, '0, 0, took);
            total++;
            if (o_valid !== exp_v || (exp_v && (o_i !== exp_i || o_q !== exp_q)))
                $display("FAIL sync_stream: v=%0b i=%h q=%h, expected v=%0b i=%h q=%h",
                         o_valid, o_i, o_q, exp_v, exp_i, exp_q);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        bit took;
        int n;
        tick(1, 1, 32'hFFF0_0000, 12'd0, 1, took);
        tick(1, 0, '0, '0, 0, took);
        n = 0;
        while (!o_valid && n < 12) begin
            tick(1, 0, '0, '0, 0, took);
            n++;
        end
        total++;
        if (o_valid !== 1'b1 || o_i !== 17'(tbl[0]))
            $display("FAIL wrap_p0: v=%0b i=%h, expected v=1 i=%h", o_valid, o_i, 17'(tbl[0]));
        else passed++;
        tick(1, 0, '0, '0, 0, took);
        total++;
        if (o_i !== 17'(-tbl[0]) || o_q !== 17'(tbl[1023]))
            $display("FAIL wrap_p4095: i=%h q=%h, expected i=%h q=%h", o_i, o_q, 17'(-tbl[0]), 17'(tbl[1023]));
        else passed++;
        tick(1, 0, '0, '0, 0, took);
        total++;
        if (o_i !== 17'(-tbl[1])) $display("FAIL wrap_p4094: i=%h, expected %h", o_i, 17'(-tbl[1]));
        else passed++;
        for (int k = 0; k < 10; k++) begin
            tick(1, 0, '0, '0, 0, took);
            total++;
            if (o_valid !== exp_v || (exp_v && (o_i !== exp_i || o_q !== exp_q)))
                $display("FAIL wrap_stream: v=%0b i=%h q=%h, expected v=%0b i=%h q=%h",
                         o_valid, o_i, o_q, exp_v, exp_i, exp_q);
            else passed++;
        end
    endtask

    task automatic test_midreset();
        bit took;
        tick(1, 1, 32'h8000_0000, 12'd5, 1, took);
        total++;
        if (o_cfg_ready !== 1'b0) $display("FAIL midreset_pend: r=%0b, expected 0", o_cfg_ready);
        else passed++;
        i_reset = 1'b1;
        #2;
        total++;
        if (o_valid !== 1'b0 || o_cfg_ready !== 1'b1 || o_i !== 17'd0 || o_q !== 17'd0)
            $display("FAIL midreset_now: v=%0b r=%0b i=%h q=%h, expected v=0 r=1 i=0 q=0",
                     o_valid, o_cfg_ready, o_i, o_q);
        else passed++;
        i_reset = 1'b0;
        model_reset();
        for (int k = 0; k < 12; k++) begin
            tick(1, 0, '0, '0, 0, took);
            total++;
            if (o_valid !== exp_v || o_cfg_ready !== exp_rdy || (exp_v && (o_i !== exp_i || o_q !== exp_q)))
                $display("FAIL midreset_run: v=%0b r=%0b i=%h q=%h, expected v=%0b r=%0b i=%h q=%h",
                         o_valid, o_cfg_ready, o_i, o_q, exp_v, exp_rdy, exp_i, exp_q);
            else passed++;
        end
        total++;
        if (o_i !== 17'(tbl[0]) || o_q !== 17'(tbl[1023]))
            $display("FAIL midreset_const: i=%h q=%h, expected i=%h q=%h", o_i, o_q, 17'(tbl[0]), 17'(tbl[1023]));
        else passed++;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++)
            tbl[k] = $rtoi(65535.0 * $sin((k + 0.5) * 3.14159265358979323846 / 2048.0) + 0.5);
        test_reset();
        test_basic();
        test_ce_toggle();
        test_reconfig();
        test_sync();
        test_wrap();
        test_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
